// File: rtl/uart_rx_pkt_ctrl.sv
// UART packet controller: generates the 16x oversample enable, parses SOF/LEN/payload/CSUM
// packets, buffers the payload and streams only checksum-verified payloads downstream.
module uart_rx_pkt_ctrl #(
  parameter int         BAUD_DIV      = 27,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_TICKS = 2048,
  parameter logic [7:0] SOF           = 8'hA5
) (
  input  logic       CLK,
  input  logic       RST,
  output logic       UART_CLK_EN,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VLD,
  input  logic       RX_FRAME_ERR,
  output logic [7:0] PAY_DATA,
  output logic       PAY_VLD,
  input  logic       PAY_RDY,
  output logic       PAY_LAST,
  output logic       PKT_OK,
  output logic       PKT_ERR,
  output logic [1:0] ERR_CODE,
  output logic       BUSY,
  output logic [7:0] DROP_CNT
);

  localparam int DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int TW = $clog2(TIMEOUT_TICKS + 1);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN8 = 8'(MAX_LEN);

  localparam logic [1:0] ERR_TIMEOUT = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_FRAME   = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM, S_DRAIN} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    len, sum, wr_idx, rd_idx;
  logic [7:0]    pay_buf [MAX_LEN];
  logic [7:0]    csum_chk;
  logic          in_pkt, tick_exp, wr_last, xfer;
  logic          abort, accept;
  logic [1:0]    err_nxt;

  // Free-running baud divider, independent of packet state
  always_ff @(posedge CLK) begin
    if (RST || div_cnt == DW'(BAUD_DIV - 1)) div_cnt <= '0;
    else                                     div_cnt <= div_cnt + DW'(1);
  end
  assign UART_CLK_EN = (div_cnt == DW'(BAUD_DIV - 1));

  // Inter-byte watchdog; held at zero while idle so it starts fresh on entry to LEN
  always_ff @(posedge CLK) begin
    if (RST || RX_VLD || state == S_IDLE) tick_cnt <= '0;
    else if (UART_CLK_EN && !tick_exp)    tick_cnt <= tick_cnt + TW'(1);
  end

  assign tick_exp = (tick_cnt == TW'(TIMEOUT_TICKS));
  assign in_pkt   = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
  assign wr_last  = (wr_idx + 8'd1 == len);
  assign csum_chk = sum + RX_DATA;
  assign xfer     = PAY_VLD && PAY_RDY;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    abort     = 1'b0;
    accept    = 1'b0;
    err_nxt   = ERR_TIMEOUT;
    if (in_pkt && RX_FRAME_ERR) begin
      abort   = 1'b1;
      err_nxt = ERR_FRAME;
    end else if (in_pkt && !RX_VLD && tick_exp) begin
      abort   = 1'b1;
      err_nxt = ERR_TIMEOUT;
    end else begin
      case (state)
        S_IDLE:    if (RX_VLD && RX_DATA == SOF) state_nxt = S_LEN;
        S_LEN:
          if (RX_VLD) begin
            if (RX_DATA == 8'd0 || RX_DATA > MAX_LEN8) begin
              abort   = 1'b1;
              err_nxt = ERR_LEN;
            end else begin
              state_nxt = S_PAYLOAD;
            end
          end
        S_PAYLOAD: if (RX_VLD && wr_last) state_nxt = S_CSUM;
        S_CSUM:
          if (RX_VLD) begin
            if (csum_chk == 8'd0) begin
              state_nxt = S_DRAIN;
              accept    = 1'b1;
            end else begin
              abort   = 1'b1;
              err_nxt = ERR_CSUM;
            end
          end
        S_DRAIN:   if (xfer && PAY_LAST) state_nxt = S_IDLE;
        default:   state_nxt = S_IDLE;
      endcase
    end
    if (abort) state_nxt = S_IDLE;
  end

  always_comb begin
    BUSY     = (state != S_IDLE);
    PAY_VLD  = (state == S_DRAIN);
    PAY_DATA = 8'd0;
    PAY_LAST = 1'b0;
    if (state == S_DRAIN) begin
      PAY_DATA = pay_buf[rd_idx[IW-1:0]];
      PAY_LAST = (rd_idx == len - 8'd1);
    end
  end

  // Payload storage is not reset; only entries below len are ever read
  always_ff @(posedge CLK) begin
    if (state == S_PAYLOAD && RX_VLD && !RX_FRAME_ERR) pay_buf[wr_idx[IW-1:0]] <= RX_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      len      <= 8'd0;
      sum      <= 8'd0;
      wr_idx   <= 8'd0;
      rd_idx   <= 8'd0;
      PKT_OK   <= 1'b0;
      PKT_ERR  <= 1'b0;
      ERR_CODE <= ERR_TIMEOUT;
      DROP_CNT <= 8'd0;
    end else begin
      PKT_OK  <= accept;
      PKT_ERR <= abort;
      if (abort) ERR_CODE <= err_nxt;
      if (RX_VLD && !RX_FRAME_ERR) begin
        if (state == S_LEN) begin
          len    <= RX_DATA;
          sum    <= RX_DATA;
          wr_idx <= 8'd0;
        end
        if (state == S_PAYLOAD) begin
          sum    <= csum_chk;
          wr_idx <= wr_idx + 8'd1;
        end
      end
      if (accept) rd_idx <= 8'd0;
      else if (xfer) rd_idx <= rd_idx + 8'd1;
      if (state == S_DRAIN && RX_VLD && DROP_CNT != 8'hFF) DROP_CNT <= DROP_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: divider, good/backpressured packets, error aborts,
// drain drop counting and mid-packet reset.
module tb_uart_rx_pkt_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       UART_CLK_EN;
  logic [7:0] RX_DATA = 8'd0;
  logic       RX_VLD = 1'b0;
  logic       RX_FRAME_ERR = 1'b0;
  logic [7:0] PAY_DATA;
  logic       PAY_VLD;
  logic       PAY_RDY = 1'b1;
  logic       PAY_LAST;
  logic       PKT_OK;
  logic       PKT_ERR;
  logic [1:0] ERR_CODE;
  logic       BUSY;
  logic [7:0] DROP_CNT;

  uart_rx_pkt_ctrl #(
    .BAUD_DIV(27), .MAX_LEN(16), .TIMEOUT_TICKS(8), .SOF(8'hA5)
  ) dut (
    .CLK(CLK), .RST(RST), .UART_CLK_EN(UART_CLK_EN),
    .RX_DATA(RX_DATA), .RX_VLD(RX_VLD), .RX_FRAME_ERR(RX_FRAME_ERR),
    .PAY_DATA(PAY_DATA), .PAY_VLD(PAY_VLD), .PAY_RDY(PAY_RDY), .PAY_LAST(PAY_LAST),
    .PKT_OK(PKT_OK), .PKT_ERR(PKT_ERR), .ERR_CODE(ERR_CODE), .BUSY(BUSY), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  int         pulses, first_pulse, bad_pos, nx, unstable, w;
  logic       stalled, hold_l;
  logic [7:0] hold_d;
  logic [7:0] got_d [3];
  logic       got_l [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the strobe covers exactly one rising edge
  task automatic send_byte(input logic [7:0] b);
    RX_DATA = b;
    RX_VLD  = 1'b1;
    @(negedge CLK);
    RX_VLD  = 1'b0;
  endtask

  task automatic send_good();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h97);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_clk_en", UART_CLK_EN, 0); chk("rst_vld", PAY_VLD, 0); chk("rst_last", PAY_LAST, 0);
    chk("rst_ok", PKT_OK, 0); chk("rst_err", PKT_ERR, 0); chk("rst_busy", BUSY, 0);
    chk("rst_data", PAY_DATA, 0); chk("rst_code", ERR_CODE, 0); chk("rst_drop", DROP_CNT, 0);

    // Divider: cycle 1 is the first cycle with RST low; pulses expected at 27, 54, 81
    RST = 1'b0;
    pulses = 0; first_pulse = 0; bad_pos = 0;
    for (int i = 1; i <= 81; i++) begin
      #1;
      if (UART_CLK_EN === 1'b1) begin
        pulses++;
        if (first_pulse == 0) first_pulse = i;
      end
      if (UART_CLK_EN !== ((i % 27) == 0)) bad_pos++;
      @(negedge CLK);
    end
    chk("div_first", first_pulse, 27);
    chk("div_count", pulses, 3);
    chk("div_pattern", bad_pos, 0);

    // Good packet, downstream always ready
    send_good();
    chk("good_ok", PKT_OK, 1); chk("good_busy", BUSY, 1); chk("good_vld0", PAY_VLD, 1);
    chk("good_d0", PAY_DATA, 8'h11); chk("good_l0", PAY_LAST, 0);
    @(negedge CLK);
    chk("good_ok_pulse", PKT_OK, 0); chk("good_d1", PAY_DATA, 8'h22); chk("good_l1", PAY_LAST, 0);
    @(negedge CLK);
    chk("good_d2", PAY_DATA, 8'h33); chk("good_l2", PAY_LAST, 1);
    @(negedge CLK);
    chk("good_vld_end", PAY_VLD, 0); chk("good_busy_end", BUSY, 0);

    // Backpressure: ready pattern 1-0-0-1-0-0-...
    send_good();
    nx = 0; unstable = 0; stalled = 1'b0; hold_d = 8'd0; hold_l = 1'b0;
    for (int k = 0; k < 20; k++) begin
      PAY_RDY = ((k % 3) == 0);
      #1;
      if (PAY_VLD === 1'b1) begin
        if (stalled && (PAY_DATA !== hold_d || PAY_LAST !== hold_l)) unstable++;
        if (PAY_RDY) begin
          if (nx < 3) begin
            got_d[nx] = PAY_DATA;
            got_l[nx] = PAY_LAST;
          end
          nx++;
        end
        stalled = !PAY_RDY;
        hold_d  = PAY_DATA;
        hold_l  = PAY_LAST;
      end else begin
        stalled = 1'b0;
      end
      @(negedge CLK);
    end
    PAY_RDY = 1'b1;
    chk("bp_xfers", nx, 3); chk("bp_stable", unstable, 0);
    chk("bp_d0", got_d[0], 8'h11); chk("bp_d1", got_d[1], 8'h22); chk("bp_d2", got_d[2], 8'h33);
    chk("bp_l0", got_l[0], 0); chk("bp_l1", got_l[1], 0); chk("bp_l2", got_l[2], 1);
    chk("bp_busy_end", BUSY, 0);

    // Checksum error
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h98);
    chk("cs_err", PKT_ERR, 1); chk("cs_code", ERR_CODE, 1); chk("cs_vld", PAY_VLD, 0);
    chk("cs_ok", PKT_OK, 0); chk("cs_busy", BUSY, 0);
    @(negedge CLK);
    chk("cs_err_pulse", PKT_ERR, 0); chk("cs_vld_after", PAY_VLD, 0);

    // Length errors: zero and one past the maximum
    send_byte(8'hA5); send_byte(8'h00);
    chk("len0_err", PKT_ERR, 1); chk("len0_code", ERR_CODE, 2);
    @(negedge CLK);
    send_byte(8'hA5); send_byte(8'h11);
    chk("len17_err", PKT_ERR, 1); chk("len17_code", ERR_CODE, 2);
    @(negedge CLK);

    // Maximum legal length: sixteen 0x01 bytes, csum 0xE0
    send_byte(8'hA5); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'h01);
    send_byte(8'hE0);
    chk("len16_ok", PKT_OK, 1); chk("len16_d0", PAY_DATA, 8'h01);
    repeat (15) @(negedge CLK);
    chk("len16_last", PAY_LAST, 1);
    @(negedge CLK);
    chk("len16_idle", BUSY, 0);

    // Single-byte packet whose payload and checksum both equal SOF-like data
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'hA5);
    chk("len1_ok", PKT_OK, 1); chk("len1_d0", PAY_DATA, 8'h5A); chk("len1_last", PAY_LAST, 1);
    @(negedge CLK);
    chk("len1_idle", BUSY, 0);

    // Framing error after the second payload byte, then a good packet
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    RX_FRAME_ERR = 1'b1;
    @(negedge CLK);
    RX_FRAME_ERR = 1'b0;
    chk("fr_err", PKT_ERR, 1); chk("fr_code", ERR_CODE, 3); chk("fr_busy", BUSY, 0);
    send_good();
    chk("fr_next_ok", PKT_OK, 1); chk("fr_next_d0", PAY_DATA, 8'h11);
    repeat (3) @(negedge CLK);

    // Timeout: 8 oversample ticks of silence inside the payload
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h11);
    w = 0;
    while (PKT_ERR !== 1'b1 && w < 400) begin
      @(negedge CLK);
      w++;
    end
    chk("to_seen", PKT_ERR, 1); chk("to_code", ERR_CODE, 0);
    chk("to_window", (w >= 185 && w <= 225), 1);
    send_good();
    chk("to_next_ok", PKT_OK, 1); chk("to_next_d0", PAY_DATA, 8'h11);
    repeat (3) @(negedge CLK);

    // Bytes arriving during a stalled drain are dropped and counted
    PAY_RDY = 1'b0;
    send_good();
    chk("drop_ok", PKT_OK, 1);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'hA5); send_byte(8'h03);
    chk("drop_cnt", DROP_CNT, 4); chk("drop_vld", PAY_VLD, 1); chk("drop_d0", PAY_DATA, 8'h11);
    PAY_RDY = 1'b1;
    repeat (4) @(negedge CLK);
    chk("drop_idle", BUSY, 0);

    // Reset mid-payload clears everything; next packet parses normally
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    RST = 1'b1;
    @(negedge CLK);
    chk("mrst_busy", BUSY, 0); chk("mrst_err", PKT_ERR, 0); chk("mrst_ok", PKT_OK, 0);
    chk("mrst_vld", PAY_VLD, 0); chk("mrst_drop", DROP_CNT, 0); chk("mrst_code", ERR_CODE, 0);
    chk("mrst_clk_en", UART_CLK_EN, 0); chk("mrst_data", PAY_DATA, 0);
    RST = 1'b0;
    send_good();
    chk("mrst_next_ok", PKT_OK, 1); chk("mrst_next_d0", PAY_DATA, 8'h11);
    repeat (4) @(negedge CLK);
    chk("mrst_next_idle", BUSY, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
